// File: rtl/display_frame_sequencer_pkg.sv
// Shared constants, state encoding and blanking rule for the LED frame sequencer.
package display_frame_sequencer_pkg;

    localparam int NUM_DIGITS        = 6;
    localparam int BITS_PER_DIGIT    = 8;
    localparam int DIGIT_SLOT_CYCLES = 1 + 2 * BITS_PER_DIGIT;
    localparam int FRAME_CYCLES      = NUM_DIGITS * DIGIT_SLOT_CYCLES + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        LATCH = 2'd3
    } seq_state_e;

    // Blink-off phase blanks masked digits; hours msd is suppressed when it reads zero.
    function automatic logic digit_blank(
        input logic [NUM_DIGITS-1:0] mask,
        input logic                  phase,
        input logic                  lz,
        input logic                  msd_zero,
        input logic [2:0]            digit
    );
        return (mask[digit] & phase) | ((digit == 3'd0) & lz & msd_zero);
    endfunction

endpackage

// File: rtl/display_frame_sequencer_if.sv
// Request/config inputs and shift-chain control outputs of the frame sequencer.
interface display_frame_sequencer_if;
    import display_frame_sequencer_pkg::*;

    logic                  en;
    logic                  frame_req;
    logic [NUM_DIGITS-1:0] blink_mask;
    logic                  blink_phase;
    logic                  lz_blank;
    logic                  hours_msd_zero;
    logic [2:0]            bcd_select;
    logic                  sr_load;
    logic                  sr_shift;
    logic                  blank;
    logic                  ext_clk;
    logic                  ext_latch;
    logic                  busy;
    logic                  frame_done;

    modport master (
        output en, frame_req, blink_mask, blink_phase, lz_blank, hours_msd_zero,
        input  bcd_select, sr_load, sr_shift, blank, ext_clk, ext_latch, busy, frame_done
    );

    modport slave (
        input  en, frame_req, blink_mask, blink_phase, lz_blank, hours_msd_zero,
        output bcd_select, sr_load, sr_shift, blank, ext_clk, ext_latch, busy, frame_done
    );

endinterface

// File: rtl/display_frame_sequencer_refresh_timer.sv
// Periodic refresh tick: down-counter holding cycles remaining, reloaded on tick or frame start.
module display_frame_sequencer_refresh_timer #(
    parameter int REFRESH_CYCLES = 1000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    input  logic restart,
    output logic tick
);

    localparam int            CW     = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(REFRESH_CYCLES - 1);

    logic [CW-1:0] remain_q;
    logic [CW-1:0] remain_d;

    assign tick = en && (remain_q == '0);

    // Disabled means frozen, so a re-enable resumes from the held count.
    always_comb begin
        remain_d = remain_q;
        if (en) begin
            if (restart || tick) begin
                remain_d = RELOAD;
            end else begin
                remain_d = remain_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            remain_q <= RELOAD;
        end else begin
            remain_q <= remain_d;
        end
    end

endmodule

// File: rtl/display_frame_sequencer.sv
// Sequences one full refresh of the 6-digit LED shift-register chain per frame start.
//   state | meaning
//   IDLE  | waiting for refresh tick, request or pending frame
//   LOAD  | parallel-load current digit into the shift register
//   SHIFT | clock out 8 bits, ext_clk low then high per bit
//   LATCH | strobe external latch, frame complete
module display_frame_sequencer
    import display_frame_sequencer_pkg::*;
#(
    parameter int REFRESH_CYCLES = 1000
) (
    input  logic                      clk,
    input  logic                      reset_n,
    display_frame_sequencer_if.slave  bus
);

    localparam logic [2:0] LAST_DIGIT = 3'(NUM_DIGITS - 1);
    localparam logic [3:0] LAST_BIT   = 4'(BITS_PER_DIGIT - 1);

    seq_state_e state_q, state_d;
    logic [2:0] digit_q, digit_d;
    logic [3:0] bit_q,   bit_d;
    logic       phase_q, phase_d;
    logic       pending_q, pending_d;
    logic       tick;
    logic       start;
    logic       restart;

    display_frame_sequencer_refresh_timer #(
        .REFRESH_CYCLES (REFRESH_CYCLES)
    ) u_refresh_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (bus.en),
        .restart (restart),
        .tick    (tick)
    );

    always_comb begin
        state_d   = state_q;
        digit_d   = digit_q;
        bit_d     = bit_q;
        phase_d   = phase_q;
        pending_d = pending_q;
        restart   = 1'b0;
        start     = tick | bus.frame_req | pending_q;
        if (!bus.en) begin
            state_d   = IDLE;
            digit_d   = 3'd0;
            bit_d     = 4'd0;
            phase_d   = 1'b0;
            pending_d = 1'b0;
        end else begin
            // Any number of requests during a frame collapse into one follow-up frame.
            if ((state_q != IDLE) && (bus.frame_req || tick)) begin
                pending_d = 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d   = LOAD;
                        digit_d   = 3'd0;
                        pending_d = 1'b0;
                        restart   = 1'b1;
                    end
                end
                LOAD: begin
                    state_d = SHIFT;
                    bit_d   = 4'd0;
                    phase_d = 1'b0;
                end
                SHIFT: begin
                    phase_d = ~phase_q;
                    if (phase_q) begin
                        if (bit_q == LAST_BIT) begin
                            if (digit_q == LAST_DIGIT) begin
                                state_d = LATCH;
                            end else begin
                                digit_d = digit_q + 3'd1;
                                state_d = LOAD;
                            end
                        end else begin
                            bit_d = bit_q + 4'd1;
                        end
                    end
                end
                LATCH: begin
                    state_d = IDLE;
                    digit_d = 3'd0;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        bus.bcd_select = 3'd0;
        bus.sr_load    = 1'b0;
        bus.sr_shift   = 1'b0;
        bus.blank      = 1'b0;
        bus.ext_clk    = 1'b0;
        bus.ext_latch  = 1'b0;
        bus.busy       = 1'b0;
        bus.frame_done = 1'b0;
        case (state_q)
            LOAD: begin
                bus.busy       = 1'b1;
                bus.sr_load    = 1'b1;
                bus.bcd_select = digit_q;
                bus.blank      = digit_blank(bus.blink_mask, bus.blink_phase,
                                             bus.lz_blank, bus.hours_msd_zero, digit_q);
            end
            SHIFT: begin
                bus.busy       = 1'b1;
                bus.bcd_select = digit_q;
                bus.ext_clk    = phase_q;
                bus.sr_shift   = phase_q;
            end
            LATCH: begin
                bus.busy       = 1'b1;
                bus.ext_latch  = 1'b1;
                bus.frame_done = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            digit_q   <= 3'd0;
            bit_q     <= 4'd0;
            phase_q   <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            digit_q   <= digit_d;
            bit_q     <= bit_d;
            phase_q   <= phase_d;
            pending_q <= pending_d;
        end
    end

endmodule

// File: tb/tb_display_frame_sequencer.sv
// Frame sequencer bench: frame-offset reference model compared every cycle, plus directed literal checks.
module tb_display_frame_sequencer;
    import display_frame_sequencer_pkg::*;

    localparam int R    = 200;
    localparam int SLOT = DIGIT_SLOT_CYCLES;

    logic clk = 1'b0;
    logic reset_n;

    display_frame_sequencer_if bus ();

    display_frame_sequencer #(.REFRESH_CYCLES(R)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial forever #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Model: position within the current frame plus refresh count since last start.
    bit m_busy = 0;
    int m_k    = 0;
    int m_cnt  = 0;
    bit m_pend = 0;

    int n_load = 0, n_rise = 0, n_done = 0;
    int busy_run = 0, last_busy_len = 0, latch_run = 0;
    int last_load_cyc = 0, last_done_cyc = 0;
    bit prev_clk = 0;
    int load_sel   [64];
    int load_blank [64];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: dut=%0d expected=%0d cycle=%0d", name, act, exp, cyc);
    endtask

    task automatic compare();
        int d, r;
        bit act, e_load, e_shift, e_latch, e_blank;
        logic [5:0] mk;
        d       = m_k / SLOT;
        r       = m_k % SLOT;
        act     = m_busy && (m_k < FRAME_CYCLES - 1);
        e_load  = act && (r == 0);
        e_shift = act && (r != 0) && (r % 2 == 0);
        e_latch = m_busy && (m_k == FRAME_CYCLES - 1);
        mk      = bus.blink_mask;
        e_blank = 0;
        if (e_load)
            e_blank = (mk[3'(d)] && bus.blink_phase) ||
                      (d == 0 && bus.lz_blank && bus.hours_msd_zero);
        check("busy",       int'(bus.busy),       int'(m_busy));
        check("sr_load",    int'(bus.sr_load),    int'(e_load));
        check("sr_shift",   int'(bus.sr_shift),   int'(e_shift));
        check("ext_clk",    int'(bus.ext_clk),    int'(e_shift));
        check("ext_latch",  int'(bus.ext_latch),  int'(e_latch));
        check("frame_done", int'(bus.frame_done), int'(e_latch));
        check("blank",      int'(bus.blank),      int'(e_blank));
        if (!e_latch) check("bcd_select", int'(bus.bcd_select), act ? d : 0);
    endtask

    task automatic stats();
        if (bus.sr_load) begin
            load_sel[n_load % 64]   = int'(bus.bcd_select);
            load_blank[n_load % 64] = int'(bus.blank);
            n_load++;
            last_load_cyc = cyc;
        end
        if (bus.ext_clk && !prev_clk) n_rise++;
        prev_clk = bus.ext_clk;
        if (bus.busy) busy_run++;
        else begin
            if (busy_run != 0) last_busy_len = busy_run;
            busy_run = 0;
        end
        if (bus.ext_latch) latch_run = busy_run;
        if (bus.frame_done) begin
            n_done++;
            last_done_cyc = cyc;
        end
    endtask

    task automatic model_update();
        bit tick;
        if (!reset_n) begin
            m_busy = 0; m_k = 0; m_cnt = 0; m_pend = 0;
        end else if (!bus.en) begin
            m_busy = 0; m_k = 0; m_pend = 0;
        end else begin
            tick  = (m_cnt == R - 1);
            m_cnt = tick ? 0 : m_cnt + 1;
            if (!m_busy) begin
                if (tick || bus.frame_req || m_pend) begin
                    m_busy = 1; m_k = 0; m_pend = 0; m_cnt = 0;
                end
            end else begin
                if (tick || bus.frame_req) m_pend = 1;
                if (m_k == FRAME_CYCLES - 1) begin
                    m_busy = 0; m_k = 0;
                end else m_k++;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        compare();
        stats();
        @(posedge clk);
        model_update();
        cyc++;
        #1;
    endtask

    task automatic pulse_req();
        bus.frame_req = 1'b1;
        step();
        bus.frame_req = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int d0 = n_done;
        int i  = 0;
        while (n_done == d0 && i < budget) begin
            step();
            i++;
        end
        check(name, int'(n_done != d0), 1);
    endtask

    task automatic wait_idle();
        int i = 0;
        while (bus.busy && i < 250) begin
            step();
            i++;
        end
        check("wait_idle", int'(bus.busy), 0);
    endtask

    task automatic blank_frame(input string name, input logic [5:0] exp);
        int l0;
        wait_idle();
        l0 = n_load;
        pulse_req();
        wait_done(150, name);
        for (int i = 0; i < 6; i++) check(name, load_blank[(l0 + i) % 64], int'(exp[i]));
    endtask

    initial begin
        int l0, r0, d0, d1, d2, d3, first_done, en_off;
        reset_n            = 1'b0;
        bus.en             = 1'b0;
        bus.frame_req      = 1'b0;
        bus.blink_mask     = '0;
        bus.blink_phase    = 1'b0;
        bus.lz_blank       = 1'b0;
        bus.hours_msd_zero = 1'b0;
        repeat (3) step();
        check("rst_outputs", int'({bus.busy, bus.sr_load, bus.sr_shift, bus.ext_clk,
                                   bus.ext_latch, bus.frame_done, bus.blank, bus.bcd_select}), 0);

        // Single requested frame from IDLE.
        reset_n = 1'b1;
        bus.en  = 1'b1;
        step();
        l0 = n_load;
        r0 = n_rise;
        pulse_req();
        wait_done(150, "req_frame_timeout");
        repeat (3) step();
        check("req_loads",     n_load - l0, 6);
        check("req_clk_rises", n_rise - r0, 48);
        check("req_latch_pos", latch_run, 103);
        check("req_busy_len",  last_busy_len, 103);
        for (int i = 0; i < 6; i++) check("req_load_sel", load_sel[(l0 + i) % 64], i);

        // Two requests while busy coalesce into one extra frame.
        d0 = n_done;
        pulse_req();
        repeat (20) step();
        pulse_req();
        repeat (30) step();
        pulse_req();
        wait_done(150, "coalesce_first_timeout");
        first_done = last_done_cyc;
        l0 = n_load;
        for (int i = 0; i < 10 && n_load == l0; i++) step();
        check("coalesce_gap", last_load_cyc - first_done, 2);
        wait_done(150, "coalesce_second_timeout");
        repeat (60) step();
        check("coalesce_count", n_done - d0, 2);

        // Periodic frames only.
        wait_done(250, "periodic_timeout");
        d1 = last_done_cyc;
        wait_done(250, "periodic_timeout");
        d2 = last_done_cyc;
        wait_done(250, "periodic_timeout");
        d3 = last_done_cyc;
        check("periodic_interval", d2 - d1, R);
        check("periodic_interval", d3 - d2, R);
        bus.en = 1'b0;
        d0 = n_done;
        repeat (500) step();
        check("disabled_no_frames", n_done - d0, 0);
        bus.en = 1'b1;

        // Blanking rules.
        bus.blink_mask  = 6'b001100;
        bus.blink_phase = 1'b1;
        blank_frame("blink_on", 6'b001100);
        bus.blink_phase = 1'b0;
        blank_frame("blink_off", 6'b000000);
        bus.blink_mask     = 6'b000000;
        bus.lz_blank       = 1'b1;
        bus.hours_msd_zero = 1'b1;
        blank_frame("lz_zero", 6'b000001);
        bus.hours_msd_zero = 1'b0;
        blank_frame("lz_nonzero", 6'b000000);
        bus.lz_blank = 1'b0;

        // Reset in the middle of a frame.
        wait_idle();
        pulse_req();
        for (int i = 0; i < 100 && busy_run < 40; i++) step();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        check("midrst_outputs", int'({bus.busy, bus.sr_load, bus.sr_shift, bus.ext_clk,
                                      bus.ext_latch, bus.frame_done, bus.blank, bus.bcd_select}), 0);
        d0 = n_done;
        repeat (120) step();
        check("midrst_no_latch", n_done - d0, 0);

        // Randomized traffic against the model.
        en_off = 0;
        for (int i = 0; i < 4000; i++) begin
            bus.frame_req = ($urandom_range(0, 29) == 0);
            if (en_off > 0) en_off--;
            else if ($urandom_range(0, 299) == 0) en_off = $urandom_range(1, 20);
            bus.en  = (en_off == 0);
            reset_n = ($urandom_range(0, 1499) != 0);
            if ($urandom_range(0, 7) == 0) bus.blink_mask = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 7) == 0) bus.blink_phase = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) bus.lz_blank = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) bus.hours_msd_zero = 1'($urandom_range(0, 1));
            step();
        end
        bus.frame_req = 1'b0;
        bus.en        = 1'b1;
        reset_n       = 1'b1;
        repeat (5) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
